// File: rtl/trivium_stream_ctrl.sv
// Trivium stream-cipher engine: key/IV reception, 1152-round warm-up, and
// DAT_W-bit-per-cycle keystream XOR with a registered, back-pressurable output.
module trivium_stream_ctrl #(
  parameter int unsigned DAT_W      = 1,
  parameter int unsigned WARMUP_RND = 1152
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             end_i,
  input  logic [DAT_W-1:0] keyiv_dat_i,
  input  logic             keyiv_vld_i,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             dat_vld_i,
  output logic             dat_rdy_o,
  output logic [DAT_W-1:0] dat_o,
  output logic             dat_vld_o,
  input  logic             dat_rdy_i,
  output logic             busy_o
);
  localparam int unsigned KBEATS = 160 / DAT_W;
  localparam int unsigned WCYC   = WARMUP_RND / DAT_W;
  localparam int unsigned KW     = $clog2(KBEATS);
  localparam int unsigned WW     = $clog2(WCYC);
  localparam logic [KW-1:0] KLAST = KW'(KBEATS - 1);
  localparam logic [WW-1:0] WLAST = WW'(WCYC - 1);

  typedef enum logic [2:0] {IDLE, RECV_INI, LOAD, WARMUP, PROC} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    kcnt_q, kcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [159:0]     sr_q, sr_d;
  logic [287:0]     s_q, s_d, s_adv;
  logic [DAT_W-1:0] ks;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;
  logic             rdy;

  // s_q[i-1] holds Trivium bit s(i); each unrolled step sees the previous step's state.
  always_comb begin : advance
    logic t1, t2, t3;
    t1    = 1'b0;
    t2    = 1'b0;
    t3    = 1'b0;
    s_adv = s_q;
    ks    = '0;
    for (int unsigned k = 0; k < DAT_W; k++) begin
      t1    = s_adv[65] ^ s_adv[92];
      t2    = s_adv[161] ^ s_adv[176];
      t3    = s_adv[242] ^ s_adv[287];
      ks[k] = t1 ^ t2 ^ t3;
      t1    = t1 ^ (s_adv[90] & s_adv[91]) ^ s_adv[170];
      t2    = t2 ^ (s_adv[174] & s_adv[175]) ^ s_adv[263];
      t3    = t3 ^ (s_adv[285] & s_adv[286]) ^ s_adv[68];
      s_adv = {s_adv[286:177], t2, s_adv[175:93], t1, s_adv[91:0], t3};
    end
  end

  always_comb begin
    state_d = state_q;
    kcnt_d  = kcnt_q;
    wcnt_d  = wcnt_q;
    sr_d    = sr_q;
    s_d     = s_q;
    dat_d   = dat_q;
    vld_d   = vld_q;
    rdy     = 1'b0;
    busy_o  = 1'b0;
    if (dat_rdy_i) vld_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (init_i) state_d = RECV_INI;
      end
      RECV_INI: begin
        busy_o = 1'b1;
        if (keyiv_vld_i) begin
          sr_d = {keyiv_dat_i, sr_q[159:DAT_W]};
          if (kcnt_q == KLAST) begin
            kcnt_d  = '0;
            state_d = LOAD;
          end else begin
            kcnt_d = kcnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        busy_o  = 1'b1;
        s_d     = {3'b111, 108'b0, 4'b0, sr_q[159:80], 13'b0, sr_q[79:0]};
        wcnt_d  = '0;
        state_d = WARMUP;
      end
      WARMUP: begin
        busy_o = 1'b1;
        s_d    = s_adv;
        if (wcnt_q == WLAST) begin
          wcnt_d  = '0;
          state_d = PROC;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      PROC: begin
        rdy = !vld_q || dat_rdy_i;
        if (dat_vld_i && rdy) begin
          dat_d = dat_i ^ ks;
          vld_d = 1'b1;
          s_d   = s_adv;
        end
        if (end_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Restart from any active state wins over end_i and drops a pending beat.
    if (init_i && state_q != IDLE) begin
      state_d = RECV_INI;
      kcnt_d  = '0;
      wcnt_d  = '0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      kcnt_q  <= '0;
      wcnt_q  <= '0;
      sr_q    <= '0;
      s_q     <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q  <= kcnt_d;
      wcnt_q  <= wcnt_d;
      sr_q    <= sr_d;
      s_q     <= s_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
    end
  end

  assign dat_rdy_o = rdy;
  assign dat_o     = dat_q;
  assign dat_vld_o = vld_q;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Self-checking bench for trivium_stream_ctrl: a DAT_W=8 instance driven by a session
// table and corner sequences, and a DAT_W=1 instance for the all-zero key/IV keystream.
module tb_trivium_stream_ctrl;
  localparam int unsigned W  = 8;
  localparam int unsigned KB = 160 / W;
  localparam int unsigned WC = 1152 / W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_init, a_end, a_kv_vld, a_dvld, a_drdy_o, a_ovld, a_ordy, a_busy;
  logic [W-1:0] a_kv, a_din, a_dout;
  logic         b_init, b_end, b_kv_vld, b_dvld, b_drdy_o, b_ovld, b_ordy, b_busy;
  logic [0:0]   b_kv, b_din, b_dout;

  trivium_stream_ctrl #(.DAT_W(W), .WARMUP_RND(1152)) dut_a (
    .clk_i(clk), .rst_i(rst), .init_i(a_init), .end_i(a_end),
    .keyiv_dat_i(a_kv), .keyiv_vld_i(a_kv_vld),
    .dat_i(a_din), .dat_vld_i(a_dvld), .dat_rdy_o(a_drdy_o),
    .dat_o(a_dout), .dat_vld_o(a_ovld), .dat_rdy_i(a_ordy), .busy_o(a_busy)
  );

  trivium_stream_ctrl #(.DAT_W(1), .WARMUP_RND(1152)) dut_b (
    .clk_i(clk), .rst_i(rst), .init_i(b_init), .end_i(b_end),
    .keyiv_dat_i(b_kv), .keyiv_vld_i(b_kv_vld),
    .dat_i(b_din), .dat_vld_i(b_dvld), .dat_rdy_o(b_drdy_o),
    .dat_o(b_dout), .dat_vld_o(b_ovld), .dat_rdy_i(b_ordy), .busy_o(b_busy)
  );

  int checks = 0;
  int errors = 0;
  bit ks_ref [0:4095];
  logic [W-1:0] prev_pt[$];
  logic [W-1:0] prev_ct[$];

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          gap;
    bit          noise;
    int          rmode;
    bit          reuse;
    int          nb;
    int          exp_busy;
  } sess_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference: 1-based state array, whole-array shift then feedback insertion.
  task automatic make_ks(input logic [79:0] key, input logic [79:0] iv, input int nbits);
    bit s [1:288];
    bit t1, t2, t3;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = key[i-1];
      s[93 + i] = iv[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      if (r >= 1152) ks_ref[r - 1152] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int j = 288; j > 1; j--) s[j] = s[j-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
    end
  endtask

  task automatic start_a(input logic [79:0] key, input logic [79:0] iv, input int gap,
                         input bit noise, input int abort_at, input int exp_busy);
    logic [159:0] kv;
    int beat, cyc, busy_n;
    kv = {iv, key}; beat = 0; cyc = 0; busy_n = 0;
    a_init = 1'b1; a_kv_vld = 1'b0;
    step();
    a_init = 1'b0;
    while (a_busy && cyc < 4000 && !(abort_at > 0 && cyc == abort_at)) begin
      busy_n++;
      if (beat < KB && (cyc % (gap + 1)) == gap) begin
        a_kv_vld = 1'b1;
        a_kv     = kv[beat*W +: W];
        beat++;
      end else begin
        a_kv_vld = 1'b0;
        a_kv     = W'($urandom);
      end
      a_end = noise ? 1'($urandom) : 1'b0;
      step();
      cyc++;
    end
    a_kv_vld = 1'b0;
    a_end    = 1'b0;
    if (abort_at == 0) begin
      chk("busy_cycles", busy_n, exp_busy);
      chk("proc_rdy", a_drdy_o, 1);
      chk("proc_vld_clear", a_ovld, 0);
    end else begin
      chk("warmup_busy", a_busy, 1);
    end
  endtask

  task automatic stream_a(input int nb, input int rmode, input bit reuse);
    bit occ, acc, last, erdy;
    logic [W-1:0] held, din;
    logic [W-1:0] pt_q[$];
    logic [W-1:0] out_q[$];
    int ptr, cyc;
    occ = 1'b0; held = '0; ptr = 0; cyc = 0;
    while (ptr < nb && cyc < 40 * nb) begin
      last   = (ptr == nb - 1);
      din    = (reuse && ptr < prev_ct.size()) ? prev_ct[ptr] : W'($urandom);
      a_din  = din;
      a_dvld = last ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (rmode)
        0:       a_ordy = 1'b1;
        1:       a_ordy = (cyc % 2 == 0);
        default: a_ordy = 1'($urandom_range(0, 1));
      endcase
      if (last) a_ordy = 1'b1;
      a_end = last;
      #1;
      erdy = !occ || a_ordy;
      chk("dat_rdy_o", a_drdy_o, erdy);
      acc = a_dvld && erdy;
      if (occ && a_ordy) out_q.push_back(held);
      if (acc) begin
        for (int i = 0; i < W; i++) held[i] = din[i] ^ ks_ref[ptr*W + i];
        occ = 1'b1;
        pt_q.push_back(din);
        ptr++;
      end else if (a_ordy) begin
        occ = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("dat_vld_o", a_ovld, occ);
      if (occ) chk("dat_o", a_dout, held);
      cyc++;
    end
    if (ptr < nb) chk("stream_timeout", ptr, nb);
    // end_i rode on the last beat: engine is IDLE but still holds that beat.
    a_end = 1'b0; a_dvld = 1'b1; a_ordy = 1'b0; a_din = W'($urandom);
    #1;
    chk("idle_rdy", a_drdy_o, 0);
    chk("idle_busy", a_busy, 0);
    step();
    chk("held_after_end", a_ovld, 1);
    chk("held_dat", a_dout, held);
    a_ordy = 1'b1;
    out_q.push_back(held);
    step();
    chk("drained", a_ovld, 0);
    a_dvld = 1'b0;
    chk("beats_out", out_q.size(), nb);
    if (reuse) begin
      for (int i = 0; i < nb && i < out_q.size() && i < prev_pt.size(); i++)
        chk("decrypt", out_q[i], prev_pt[i]);
    end else begin
      prev_pt = pt_q;
      prev_ct = out_q;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sess_t tab [4];
    logic [79:0] k1, iv1, k3, iv3;
    int n, cyc;

    k1  = {$urandom, $urandom, 16'($urandom)};
    iv1 = {$urandom, $urandom, 16'($urandom)};
    tab[0] = '{k1, iv1, 0, 1'b0, 0, 1'b0, 30, 0};
    tab[1] = '{k1, iv1, 3, 1'b1, 1, 1'b1, 30, 0};
    tab[2] = '{{$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)},
               1, 1'b0, 2, 1'b0, 40, 0};
    tab[3] = '{'1, '0, 0, 1'b1, 2, 1'b0, 20, 0};
    for (int i = 0; i < 4; i++) tab[i].exp_busy = KB * (tab[i].gap + 1) + 1 + WC;

    rst = 1'b1;
    a_init = 0; a_end = 0; a_kv_vld = 0; a_kv = '0; a_dvld = 0; a_din = '0; a_ordy = 0;
    b_init = 0; b_end = 0; b_kv_vld = 0; b_kv = '0; b_dvld = 0; b_din = '0; b_ordy = 0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_a_dat", a_dout, 0);
    chk("rst_a_vld", a_ovld, 0);
    chk("rst_a_rdy", a_drdy_o, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_vld", b_ovld, 0);
    chk("rst_b_busy", b_busy, 0);

    // DAT_W=1, all-zero key/IV
    make_ks('0, '0, 64);
    b_init = 1'b1;
    step();
    b_init = 1'b0;
    n = 0; cyc = 0;
    while (b_busy && cyc < 3000) begin
      n++;
      b_kv_vld = (cyc < 160);
      b_kv     = 1'b0;
      step();
      cyc++;
    end
    b_kv_vld = 1'b0;
    chk("w1_busy_cycles", n, 160 + 1 + 1152);
    b_dvld = 1'b1; b_ordy = 1'b1; b_din = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("w1_vld", b_ovld, 1);
      chk("w1_keystream", b_dout, ks_ref[i]);
    end
    b_dvld = 1'b0; b_end = 1'b1;
    step();
    b_end = 1'b0;
    chk("w1_idle_rdy", b_drdy_o, 0);

    // DAT_W=8 session table
    for (int i = 0; i < 4; i++) begin
      make_ks(tab[i].key, tab[i].iv, tab[i].nb * W);
      start_a(tab[i].key, tab[i].iv, tab[i].gap, tab[i].noise, 0, tab[i].exp_busy);
      stream_a(tab[i].nb, tab[i].rmode, tab[i].reuse);
    end

    // restart from PROC with a held beat (init_i and end_i together), then mid-warm-up
    start_a(k1, iv1, 0, 1'b0, 0, KB + 1 + WC);
    a_dvld = 1'b1; a_din = W'($urandom); a_ordy = 1'b0;
    step();
    chk("held_before_restart", a_ovld, 1);
    a_dvld = 1'b0; a_init = 1'b1; a_end = 1'b1;
    step();
    a_init = 1'b0; a_end = 1'b0;
    chk("restart_vld", a_ovld, 0);
    chk("restart_busy", a_busy, 1);
    chk("restart_rdy", a_drdy_o, 0);
    start_a({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)},
            0, 1'b0, KB + 1 + 50, 0);
    k3  = {$urandom, $urandom, 16'($urandom)};
    iv3 = {$urandom, $urandom, 16'($urandom)};
    make_ks(k3, iv3, 20 * W);
    start_a(k3, iv3, 0, 1'b0, 0, KB + 1 + WC);
    stream_a(20, 2, 1'b0);

    // synchronous reset in PROC with a pending output beat
    start_a(k3, iv3, 0, 1'b0, 0, KB + 1 + WC);
    a_dvld = 1'b1; a_din = W'($urandom); a_ordy = 1'b0;
    step();
    chk("held_before_rst", a_ovld, 1);
    rst = 1'b1; a_dvld = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_vld", a_ovld, 0);
    chk("midrst_dat", a_dout, 0);
    chk("midrst_rdy", a_drdy_o, 0);
    chk("midrst_busy", a_busy, 0);
    a_dvld = 1'b1; a_ordy = 1'b1;
    #1;
    chk("midrst_idle_rdy", a_drdy_o, 0);
    step();
    chk("midrst_idle_vld", a_ovld, 0);
    a_dvld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
